// File: rtl/rr_priority_arbiter.sv
// N-input priority arbiter with registered grant and valid/ready handshake.
// Fixed (highest index wins) or round-robin (rotating pointer) arbitration.
module rr_priority_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    logic             accept;
    logic             load;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;
    logic             win_found;

    always_comb begin
        accept   = out_valid & out_ready;
        load     = ~out_valid | out_ready;
        ptr_next = ptr;
        if (accept && rr_mode) begin
            ptr_next = (out_idx == '0) ? TOP : out_idx - ONE;
        end
        base = rr_mode ? ptr_next : TOP;
    end

    // Descending search from base, wrapping 0 -> N-1 so indices >= N never appear.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = base;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == '0) ? TOP : cand - ONE;
        end
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            ptr        <= TOP;
        end else begin
            ptr <= ptr_next;
            if (load) begin
                if (win_found) begin
                    out_valid  <= 1'b1;
                    out_idx    <= win_idx;
                    out_onehot <= win_onehot;
                end else begin
                    out_valid  <= 1'b0;
                    out_onehot <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed-vector bench for rr_priority_arbiter (N=8 and N=5 instances).
module tb_rr_priority_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8 = 1'b0;
    logic [7:0] req8 = '0;
    logic       rr8 = 1'b0;
    logic       rdy8 = 1'b0;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;

    logic       rst5 = 1'b0;
    logic [4:0] req5 = '0;
    logic       rr5 = 1'b0;
    logic       rdy5 = 1'b0;
    logic       v5;
    logic [2:0] idx5;
    logic [4:0] oh5;

    rr_priority_arbiter #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst8), .req(req8), .rr_mode(rr8),
        .out_ready(rdy8), .out_valid(v8), .out_idx(idx8), .out_onehot(oh8)
    );

    rr_priority_arbiter #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst5), .req(req5), .rr_mode(rr5),
        .out_ready(rdy5), .out_valid(v5), .out_idx(idx5), .out_onehot(oh5)
    );

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       rr;
        logic       rdy;
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
    } vec_t;

    vec_t vt[35];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] q,
                                input logic m, input logic y, input logic v,
                                input logic [2:0] i, input logic [7:0] o);
        vec_t t;
        t.rst_n = r; t.req = q; t.rr = m; t.rdy = y;
        t.v = v; t.idx = i; t.oh = o;
        return t;
    endfunction

    logic [2:0] rr5_seq[6];
    logic [4:0] rr5_oh[6];

    initial begin
        // reset, fixed priority, then backpressure
        vt[0]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[1]  = mk(1, 8'h26, 0, 1, 1, 5, 8'h20);
        vt[2]  = mk(1, 8'h00, 0, 1, 0, 5, 8'h00);
        vt[3]  = mk(1, 8'h26, 0, 0, 1, 5, 8'h20);
        vt[4]  = mk(1, 8'h80, 0, 0, 1, 5, 8'h20);
        vt[5]  = mk(1, 8'h80, 0, 0, 1, 5, 8'h20);
        vt[6]  = mk(1, 8'h80, 0, 0, 1, 5, 8'h20);
        vt[7]  = mk(1, 8'h80, 0, 1, 1, 7, 8'h80);
        vt[8]  = mk(1, 8'h00, 0, 1, 0, 7, 8'h00);
        // round-robin full rotation
        vt[9]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[10] = mk(1, 8'hFF, 1, 1, 1, 7, 8'h80);
        vt[11] = mk(1, 8'hFF, 1, 1, 1, 6, 8'h40);
        vt[12] = mk(1, 8'hFF, 1, 1, 1, 5, 8'h20);
        vt[13] = mk(1, 8'hFF, 1, 1, 1, 4, 8'h10);
        vt[14] = mk(1, 8'hFF, 1, 1, 1, 3, 8'h08);
        vt[15] = mk(1, 8'hFF, 1, 1, 1, 2, 8'h04);
        vt[16] = mk(1, 8'hFF, 1, 1, 1, 1, 8'h02);
        vt[17] = mk(1, 8'hFF, 1, 1, 1, 0, 8'h01);
        vt[18] = mk(1, 8'hFF, 1, 1, 1, 7, 8'h80);
        // sparse round-robin, then fixed mode
        vt[19] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00);
        vt[20] = mk(1, 8'h81, 1, 1, 1, 7, 8'h80);
        vt[21] = mk(1, 8'h81, 1, 1, 1, 0, 8'h01);
        vt[22] = mk(1, 8'h81, 1, 1, 1, 7, 8'h80);
        vt[23] = mk(1, 8'h81, 1, 1, 1, 0, 8'h01);
        vt[24] = mk(1, 8'h81, 0, 1, 1, 7, 8'h80);
        vt[25] = mk(1, 8'h81, 0, 1, 1, 7, 8'h80);
        vt[26] = mk(1, 8'h81, 0, 1, 1, 7, 8'h80);
        vt[27] = mk(1, 8'hFF, 1, 1, 1, 6, 8'h40);
        // reset while holding a grant
        vt[28] = mk(1, 8'hFF, 1, 0, 1, 6, 8'h40);
        vt[29] = mk(0, 8'hFF, 1, 0, 0, 0, 8'h00);
        vt[30] = mk(1, 8'hFF, 1, 1, 1, 7, 8'h80);
        vt[31] = mk(1, 8'hFF, 1, 1, 1, 6, 8'h40);
        // ready while idle must not move the pointer
        vt[32] = mk(1, 8'h00, 1, 1, 0, 6, 8'h00);
        vt[33] = mk(1, 8'h00, 1, 1, 0, 6, 8'h00);
        vt[34] = mk(1, 8'hFF, 1, 1, 1, 5, 8'h20);

        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            rst8 = vt[i].rst_n;
            req8 = vt[i].req;
            rr8  = vt[i].rr;
            rdy8 = vt[i].rdy;
            @(posedge clk);
            #1;
            check("valid8", i, 32'(v8), 32'(vt[i].v));
            check("idx8", i, 32'(idx8), 32'(vt[i].idx));
            check("onehot8", i, 32'(oh8), 32'(vt[i].oh));
        end

        // N=5 round-robin wraps 0 -> 4
        rr5_seq = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        rr5_oh  = '{5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h10};
        @(negedge clk);
        rst5 = 1'b0;
        @(posedge clk);
        #1;
        check("valid5_rst", 0, 32'(v5), 32'd0);
        @(negedge clk);
        rst5 = 1'b1; req5 = 5'b11111; rr5 = 1'b1; rdy5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("valid5", i, 32'(v5), 32'd1);
            check("idx5", i, 32'(idx5), 32'(rr5_seq[i]));
            check("onehot5", i, 32'(oh5), 32'(rr5_oh[i]));
            check("idx5_range", i, 32'(idx5 <= 3'd4), 32'd1);
        end

        // N=5 fixed mode, highest set index wins
        @(negedge clk);
        req5 = 5'b01010; rr5 = 1'b0;
        @(posedge clk);
        #1;
        check("idx5_fixed", 0, 32'(idx5), 32'd3);
        check("onehot5_fixed", 0, 32'(oh5), 32'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
Parametrised N-input priority encoder with registered output and a valid/ready handshake. It is the sequential successor of the 4:2 combinational encoder. It supports two arbitration modes, selected at runtime by rr_mode:
- fixed priority: highest index wins;
- round-robin: rotating priority, so every requester gets served.
It sits between request sources (DMA channels, interrupt lines) and a single shared consumer. The consumer accepts one grant at a time.

Parameters:
- N, 8, number of request inputs; legal range 2..64; need not be a power of two.
- IDX_W, $clog2(N), width of the encoded index. Derived: do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  N  request vector; bit i asserted means requester i wants service.
- rr_mode  input  1  0 = fixed priority; 1 = round-robin.
- out_ready  input  1  consumer accepts the current grant this cycle.
- out_valid  output  1  a grant is being presented.
- out_idx  output  IDX_W  encoded index of the granted requester.
- out_onehot  output  N  one-hot form of out_idx; all zero when out_valid=0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_idx=0, out_onehot=0, ptr=N-1.
  - Reset overrides any in-flight grant; the held grant is dropped.
- All outputs are registered. No combinational path exists from req or out_ready to any output.
- Internal pointer ptr, IDX_W bits, holds the highest-priority index for the next arbitration.
- Priority search: start at the base index and go descending, wrapping from 0 to N-1. The first asserted req bit wins.
  - Fixed mode: base = N-1.
  - Round-robin mode: base = ptr.
- Load condition: out_valid=0, or (out_valid=1 and out_ready=1).
  - When the load condition holds and req != 0: out_valid<=1, and out_idx/out_onehot are set to the search winner.
  - When the load condition holds and req == 0: out_valid<=0 and out_onehot<=0. out_idx keeps its old value.
- Latency: req sampled at edge t produces its grant at the outputs after edge t, i.e. 1 cycle. No bubble is inserted between back-to-back accepts.
- Hold: while out_valid=1 and out_ready=0, out_idx and out_onehot stay stable. Changes on req are ignored, including deassertion of the granted bit; there is no revocation.
- Pointer update: on an accept (out_valid and out_ready) with rr_mode=1, ptr <= (out_idx==0) ? N-1 : out_idx-1.
  - The winner of an arbitration in that same load cycle uses the updated ptr. Compute it combinationally from the next-ptr value.
  - With rr_mode=0, ptr is not modified.
- Mode switch: rr_mode is sampled only in load cycles. Switching modes does not reset ptr.
- Wrap-around: ptr and the search wrap modulo N. This also applies for non-power-of-two N; indices at or above N are never produced.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. N=8, rr_mode=0, out_ready=1, req=8'b0010_0110 -> after 1 edge: out_valid=1, out_idx=5, out_onehot=8'b0010_0000. Then req=0 -> next cycle out_valid=0, out_onehot=0.
2. Backpressure, N=8, fixed mode: grant idx 5 presented, out_ready=0 for 3 cycles, req changed to 8'h80 -> out_idx holds at 5 for all 3 cycles. At the edge where out_ready=1 -> next cycle out_idx=7, out_valid=1 (no bubble).
3. Round-robin, N=8, req=8'hFF held, out_ready=1 from reset -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, out_valid constantly 1.
4. Round-robin sparse, N=8, req=8'b1000_0001 -> out_idx 7,0,7,0. Then switch rr_mode=0 -> out_idx stays 7 every cycle.
5. Reset mid-operation: out_valid=1, out_ready=0, rst_n=0 for 1 edge -> out_valid=0, out_onehot=0. With req=8'hFF, rr_mode=1 after release, the first grant is idx 7 (ptr restored to N-1).
6. N=5 instance, round-robin, req=5'b11111, out_ready=1 -> out_idx 4,3,2,1,0,4; out_idx never exceeds 4.
